// File: rtl/regbank_arb_pkg.sv
// Shared types and helpers for the two-master register-bank Wishbone arbiter.
package regbank_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    localparam logic OwnerM0 = 1'b0;
    localparam logic OwnerM1 = 1'b1;

    // Counter must hold TIMEOUT-1; keep at least one bit for tiny timeouts.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Cycle counter for an owned transaction; flags expiry at TIMEOUT-1 owned cycles.
module wb_arb_watchdog
    import regbank_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic active,
    output logic expire
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = active & (cnt_q == CntMax);

endmodule

// File: rtl/regbank_wb_arbiter2.sv
// Round-robin arbiter sharing one pipelined Wishbone register-bank slave between two masters,
// with a watchdog that forces err on transactions the slave never answers.
module regbank_wb_arbiter2
    import regbank_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W+1:2] m0_adr_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    output logic              m0_stall_o,
    output logic [31:0]       m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W+1:2] m1_adr_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic              m1_stall_o,
    output logic [31:0]       m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W+1:2] s_adr_o,
    output logic [3:0]        s_sel_o,
    output logic [31:0]       s_dat_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    input  logic              s_stall_i,
    input  logic [31:0]       s_dat_i
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic req0, req1, own0, own1, owning, owner;
    logic owner_cyc, other_req, resp, expire, force_err, release_bus, abort;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign own0      = (state_q == StOwn0);
    assign own1      = (state_q == StOwn1);
    assign owning    = own0 | own1;
    assign owner     = own1 ? OwnerM1 : OwnerM0;
    assign owner_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign other_req = own1 ? req0 : req1;

    // Responses only count while a master owns the bus; late ones in idle are dropped.
    assign resp        = owning & (s_ack_i | s_err_i | s_rty_i);
    assign force_err   = expire & ~resp;
    assign release_bus = resp | force_err;
    assign abort       = owning & ~owner_cyc;

    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clr    (~owning | release_bus | abort),
        .en     (owning & ~resp),
        .active (owning),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (last_grant_q == OwnerM1) begin
                    if (req0)      state_d = StOwn0;
                    else if (req1) state_d = StOwn1;
                end else begin
                    if (req1)      state_d = StOwn1;
                    else if (req0) state_d = StOwn0;
                end
            end
            StOwn0, StOwn1: begin
                if (release_bus) begin
                    last_grant_d = owner;
                    // Direct handover avoids an idle bubble when the other master waits.
                    if (other_req) state_d = own1 ? StOwn0 : StOwn1;
                    else           state_d = StIdle;
                end else if (abort) begin
                    last_grant_d = owner;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            last_grant_q <= OwnerM1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_sel_o    = '0;
        s_dat_o    = '0;
        m0_stall_o = req0;
        m1_stall_o = req1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        if (owning) begin
            s_cyc_o = owner_cyc & ~force_err;
            s_stb_o = (own1 ? m1_stb_i : m0_stb_i) & owner_cyc & ~force_err;
            s_we_o  = own1 ? m1_we_i  : m0_we_i;
            s_adr_o = own1 ? m1_adr_i : m0_adr_i;
            s_sel_o = own1 ? m1_sel_i : m0_sel_i;
            s_dat_o = own1 ? m1_dat_i : m0_dat_i;
        end
        if (own0) begin
            m0_stall_o = s_stall_i;
            m0_ack_o   = s_ack_i;
            m0_err_o   = s_err_i | force_err;
            m0_rty_o   = s_rty_i;
        end
        if (own1) begin
            m1_stall_o = s_stall_i;
            m1_ack_o   = s_ack_i;
            m1_err_o   = s_err_i | force_err;
            m1_rty_o   = s_rty_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_regbank_wb_arbiter2.sv
// Scoreboard bench for regbank_wb_arbiter2: queued master transactions, a simple slave model,
// expected responses checked in grant order as the masters receive them.
module tb_regbank_wb_arbiter2;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        int          drop_after;
    } txn_t;

    typedef struct {
        int          m;
        logic [2:0]  kind;   // {rty, err, ack}
        logic [31:0] dat;
        logic        chk_dat;
    } exp_t;

    logic clk, rst_n;
    logic mcyc[2], mstb[2], mwe[2];
    logic [3:0]  madr[2];
    logic [31:0] mdat[2];
    logic m0_ack, m0_err, m0_rty, m0_stall, m1_ack, m1_err, m1_rty, m1_stall;
    logic [31:0] m0_rdat, m1_rdat;
    logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty, s_stall;
    logic [3:0]  s_adr, s_sel;
    logic [31:0] s_wdat, s_rdat;

    txn_t mq0[$], mq1[$];
    exp_t exp_q[$];
    bit [31:0] model_mem[16];
    logic act[2];
    int   age[2], drop[2];
    logic [1:0] resp_seen;
    int ack_cnt[2];
    int n_checks, n_errors;

    // Slave model
    logic mute, pend;
    int   delay, cnt;
    bit [31:0] mem[16];
    logic [31:0] rdata;

    regbank_wb_arbiter2 #(
        .ADDR_W (4),
        .TIMEOUT(8)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .m0_cyc_i  (mcyc[0]),
        .m0_stb_i  (mstb[0]),
        .m0_we_i   (mwe[0]),
        .m0_adr_i  (madr[0]),
        .m0_sel_i  (4'hF),
        .m0_dat_i  (mdat[0]),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m0_rty_o  (m0_rty),
        .m0_stall_o(m0_stall),
        .m0_dat_o  (m0_rdat),
        .m1_cyc_i  (mcyc[1]),
        .m1_stb_i  (mstb[1]),
        .m1_we_i   (mwe[1]),
        .m1_adr_i  (madr[1]),
        .m1_sel_i  (4'hF),
        .m1_dat_i  (mdat[1]),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .m1_rty_o  (m1_rty),
        .m1_stall_o(m1_stall),
        .m1_dat_o  (m1_rdat),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_adr_o   (s_adr),
        .s_sel_o   (s_sel),
        .s_dat_o   (s_wdat),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rty_i   (s_rty),
        .s_stall_i (s_stall),
        .s_dat_i   (s_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic add_txn(input int m, input logic we, input logic [3:0] adr,
                           input logic [31:0] dat, input int drop_after);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.drop_after = drop_after;
        if (m == 0) mq0.push_back(t);
        else        mq1.push_back(t);
    endtask

    task automatic expect_resp(input int m, input logic [2:0] kind, input logic [31:0] dat,
                               input logic chk_dat);
        exp_t e;
        e.m = m; e.kind = kind; e.dat = dat; e.chk_dat = chk_dat;
        exp_q.push_back(e);
    endtask

    // Slave: accepts one request at a time, answers `delay` cycles after the accept cycle + 1.
    assign s_ack   = pend && (cnt == 0) && !mute;
    assign s_err   = 1'b0;
    assign s_rty   = 1'b0;
    assign s_stall = 1'b0;
    assign s_rdat  = rdata;

    always @(posedge clk) begin
        if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end else if (s_cyc && s_stb && !mute) begin
            pend <= 1'b1;
            cnt  <= delay;
            if (s_we) mem[s_adr] <= s_wdat;
            else      rdata      <= mem[s_adr] ^ 32'hDEADBEEF;
        end
    end

    // Master drivers: hold cyc/stb until a response (or planned drop), then take the next txn.
    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            txn_t t;
            logic got;
            got = 1'b0;
            if (!rst_n) begin
                act[m] = 1'b0; mcyc[m] = 1'b0; mstb[m] = 1'b0;
            end else begin
                if (act[m]) begin
                    age[m]++;
                    if (resp_seen[m] || (drop[m] != 0 && age[m] == drop[m])) begin
                        act[m] = 1'b0; mcyc[m] = 1'b0; mstb[m] = 1'b0;
                    end
                end
                if (!act[m]) begin
                    if (m == 0 && mq0.size() > 0) begin t = mq0.pop_front(); got = 1'b1; end
                    if (m == 1 && mq1.size() > 0) begin t = mq1.pop_front(); got = 1'b1; end
                    if (got) begin
                        act[m] = 1'b1; age[m] = 0; drop[m] = t.drop_after;
                        mcyc[m] = 1'b1; mstb[m] = 1'b1;
                        mwe[m] = t.we; madr[m] = t.adr; mdat[m] = t.dat;
                    end
                end
            end
        end
    end

    // Response monitor: every master response must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [2:0]  kind;
            logic [31:0] d;
            kind = (m == 0) ? {m0_rty, m0_err, m0_ack} : {m1_rty, m1_err, m1_ack};
            d    = (m == 0) ? m0_rdat : m1_rdat;
            resp_seen[m] = |kind;
            if (|kind) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_resp_m%0d", m), 32'(kind), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_master", m, e.m);
                    check("resp_kind", 32'(kind), 32'(e.kind));
                    if (e.chk_dat) check("resp_rdata", d, e.dat);
                    if (kind[0]) ack_cnt[m]++;
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && mq0.size() == 0 && mq1.size() == 0 && !act[0] && !act[1])
                break;
            @(negedge clk);
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int a0, a1;
        logic [2:0] any_resp;
        rst_n = 1'b0; mute = 1'b0; delay = 0; pend = 1'b0; cnt = 0; rdata = '0;
        resp_seen = '0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
            madr[m] = '0; mdat[m] = '0; age[m] = 0; drop[m] = 0; ack_cnt[m] = 0;
        end
        n_checks = 0; n_errors = 0;
        repeat (3) @(negedge clk);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_m_resp", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single read, ack one cycle after strobe
        add_txn(0, 1'b0, 4'h0, 32'h0, 0);
        expect_resp(0, 3'b001, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        check("t1_idle_stb", 32'(s_stb), 32'd0);
        check("t1_idle_stall", 32'(m0_stall), 32'd1);
        @(negedge clk);
        check("t1_stb", 32'(s_stb), 32'd1);
        check("t1_adr", 32'(s_adr), 32'd0);
        check("t1_stall", 32'(m0_stall), 32'd0);
        @(negedge clk);
        check("t1_ack", 32'(m0_ack), 32'd1);
        check("t1_dat", m0_rdat, 32'hDEADBEEF);
        check("t1_m1_ack", 32'(m1_ack), 32'd0);
        wait_drain(50);

        // 2: simultaneous requests after reset, m0 first, direct handover
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        add_txn(0, 1'b0, 4'h1, 32'h0, 0);
        add_txn(1, 1'b0, 4'h2, 32'h0, 0);
        expect_resp(0, 3'b001, model_mem[1] ^ 32'hDEADBEEF, 1'b1);
        expect_resp(1, 3'b001, model_mem[2] ^ 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        check("t2_stall_m1_idle", 32'(m1_stall), 32'd1);
        @(negedge clk);
        check("t2_adr_m0", 32'(s_adr), 32'd1);
        check("t2_stall_m1_own0", 32'(m1_stall), 32'd1);
        @(negedge clk);
        check("t2_ack_m0", 32'(m0_ack), 32'd1);
        check("t2_stall_m1_ack", 32'(m1_stall), 32'd1);
        @(negedge clk);
        check("t2_handover_stb", 32'(s_stb), 32'd1);
        check("t2_handover_adr", 32'(s_adr), 32'd2);
        check("t2_stall_m1_own1", 32'(m1_stall), 32'd0);
        wait_drain(50);

        // 3: four writes from m0 interleaved with four reads from m1
        a0 = ack_cnt[0]; a1 = ack_cnt[1];
        for (int i = 0; i < 4; i++) begin
            add_txn(0, 1'b1, 4'(4 + i), 32'h1000 + i, 0);
            model_mem[4 + i] = 32'h1000 + i;
            expect_resp(0, 3'b001, 32'h0, 1'b0);
            add_txn(1, 1'b0, 4'(4 + i), 32'h0, 0);
            expect_resp(1, 3'b001, model_mem[4 + i] ^ 32'hDEADBEEF, 1'b1);
        end
        wait_drain(200);
        check("t3_m0_acks", ack_cnt[0] - a0, 4);
        check("t3_m1_acks", ack_cnt[1] - a1, 4);

        // 4: slave silent -> forced err on the 8th owned cycle
        mute = 1'b1;
        add_txn(0, 1'b0, 4'h3, 32'h0, 0);
        expect_resp(0, 3'b010, 32'h0, 1'b0);
        @(negedge clk);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t4_cyc_c%0d", k), 32'(s_cyc), 32'd1);
            check($sformatf("t4_noerr_c%0d", k), 32'(m0_err), 32'd0);
        end
        @(negedge clk);
        check("t4_err", 32'(m0_err), 32'd1);
        check("t4_err_cyc", 32'(s_cyc), 32'd0);
        @(negedge clk);
        check("t4_after_err", 32'(m0_err), 32'd0);
        check("t4_after_cyc", 32'(s_cyc), 32'd0);
        wait_drain(50);
        mute = 1'b0;

        // 5: m1 abandons its cycle; the slave's late ack must not reach anyone
        delay = 2;
        add_txn(1, 1'b0, 4'h5, 32'h0, 2);
        @(negedge clk);
        check("t5_stall_idle", 32'(m1_stall), 32'd1);
        @(negedge clk);
        check("t5_stb", 32'(s_stb), 32'd1);
        check("t5_adr", 32'(s_adr), 32'd5);
        @(negedge clk);
        check("t5_abort_cyc", 32'(s_cyc), 32'd0);
        @(negedge clk);
        check("t5_idle_cyc", 32'(s_cyc), 32'd0);
        @(negedge clk);
        check("t5_stray_m1", 32'({m1_ack, m1_err}), 32'd0);
        check("t5_stray_m0", 32'({m0_ack, m0_err}), 32'd0);
        delay = 0;
        add_txn(0, 1'b0, 4'h5, 32'h0, 0);
        expect_resp(0, 3'b001, model_mem[5] ^ 32'hDEADBEEF, 1'b1);
        wait_drain(50);

        // 6: reset in the middle of an owned transaction
        delay = 5;
        add_txn(1, 1'b0, 4'h6, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_cyc_before_rst", 32'(s_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", 32'(s_cyc), 32'd0);
        check("t6_rst_stb", 32'(s_stb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_resp = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            any_resp = any_resp | {m0_ack | m1_ack, m0_err | m1_err, s_cyc};
        end
        check("t6_no_resp_after_rst", 32'(any_resp), 32'd0);
        delay = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
